// File: rtl/escalonador_pkg.sv
// escalonador_pkg: shared FSM state/reason enums, default parameter values and PC override constants
package escalonador_pkg;
    typedef enum logic [2:0] {OCIOSO, EXECUTA, SALVA, SELECIONA, CARREGA} estado_t;
    typedef enum logic [1:0] {MOT_QUANTUM, MOT_IO, MOT_FIM} motivo_t;
    localparam int N_PROC_PADRAO    = 10;
    localparam int PC_W_PADRAO      = 32;
    localparam int QUANTUM_PADRAO   = 16;
    localparam int PROC_SPAN_PADRAO = 300;
    localparam int PC_RESET         = 0;
    function automatic int pc_base(input int id, input int span);
        return id * span;
    endfunction
endpackage

// File: rtl/escalonador_processos_if.sv
// escalonador_processos_if: CPU-side signals of the process scheduler
interface escalonador_processos_if
    import escalonador_pkg::*;
#(
    parameter int N_PROC = N_PROC_PADRAO,
    parameter int PC_W   = PC_W_PADRAO
);
    localparam int ID_W = $clog2(N_PROC);
    logic              step;
    logic [PC_W-1:0]   pc_desvio;
    logic              cria_valido;
    logic [ID_W-1:0]   cria_id;
    logic              fim_processo;
    logic              io_pedido;
    logic              io_concluido;
    logic [ID_W-1:0]   io_id;
    logic [PC_W-1:0]   pc_proximo;
    logic              carrega_pc;
    logic [ID_W-1:0]   processo_atual;
    logic              troca_contexto;
    logic              ocioso;
    logic [N_PROC-1:0] ativos;
    modport master (
        output step, pc_desvio, cria_valido, cria_id, fim_processo, io_pedido, io_concluido, io_id,
        input  pc_proximo, carrega_pc, processo_atual, troca_contexto, ocioso, ativos
    );
    modport slave (
        input  step, pc_desvio, cria_valido, cria_id, fim_processo, io_pedido, io_concluido, io_id,
        output pc_proximo, carrega_pc, processo_atual, troca_contexto, ocioso, ativos
    );
endinterface

// File: rtl/escalonador_processos_seletor.sv
// seletor_round_robin: first requesting slot at or after i_inicio, wrapping modulo N_PROC
module seletor_round_robin #(
    parameter int N_PROC = 10,
    parameter int ID_W   = $clog2(N_PROC)
) (
    input  logic [N_PROC-1:0] i_req,
    input  logic [ID_W-1:0]   i_inicio,
    output logic [ID_W-1:0]   o_grant,
    output logic              o_valid
);
    logic [ID_W:0] w_idx;
    // Scanning from the far end lets the nearest hit overwrite the earlier ones
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int i = N_PROC - 1; i >= 0; i--) begin
            w_idx = {1'b0, i_inicio} + (ID_W+1)'(i);
            w_idx = (w_idx >= (ID_W+1)'(N_PROC)) ? w_idx - (ID_W+1)'(N_PROC) : w_idx;
            if (i_req[w_idx[ID_W-1:0]]) begin
                o_grant = w_idx[ID_W-1:0];
                o_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/escalonador_processos.sv
// escalonador_processos: round-robin time-slice process scheduler driving PC overrides.
// Optional macro ESCALONADOR_IO_BLOQUEIO_EN: io_pedido blocks the slot until io_concluido.
module escalonador_processos
    import escalonador_pkg::*;
#(
    parameter int N_PROC    = N_PROC_PADRAO,
    parameter int PC_W      = PC_W_PADRAO,
    parameter int QUANTUM   = QUANTUM_PADRAO,
    parameter int PROC_SPAN = PROC_SPAN_PADRAO
) (
    input  logic                   clock,
    input  logic                   reset,
    escalonador_processos_if.slave bus
);
    localparam int ID_W = $clog2(N_PROC);

    estado_t           r_estado;
    motivo_t           r_motivo;
    logic [N_PROC-1:0] r_pronto;
    logic [N_PROC-1:0] r_bloq;
    logic [PC_W-1:0]   r_pc [N_PROC];
    logic [7:0]        r_quantum;
    logic [ID_W-1:0]   r_atual;
    logic [PC_W-1:0]   r_pc_proximo;
    logic              r_carrega;
    logic              r_troca;
    logic              r_ocioso;
    logic [N_PROC-1:0] w_ativos;
    logic [ID_W-1:0]   w_inicio;
    logic [ID_W-1:0]   w_grant;
    logic              w_valid;
    logic              w_io;
    logic              w_exp;

    assign w_ativos = r_pronto | r_bloq;
    assign w_inicio = (r_atual == ID_W'(N_PROC - 1)) ? '0 : r_atual + ID_W'(1);
    assign w_exp    = bus.step && (r_quantum == 8'd1);
`ifdef ESCALONADOR_IO_BLOQUEIO_EN
    assign w_io     = bus.io_pedido;
`else
    assign w_io     = 1'b0;
`endif

    seletor_round_robin #(.N_PROC(N_PROC), .ID_W(ID_W)) u_seletor (
        .i_req   (r_pronto),
        .i_inicio(w_inicio),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    // Slot-table writes precede the FSM so a SALVA update wins same-cycle conflicts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado     <= OCIOSO;
            r_motivo     <= MOT_QUANTUM;
            r_pronto     <= '0;
            r_bloq       <= '0;
            for (int i = 0; i < N_PROC; i++) r_pc[i] <= '0;
            r_quantum    <= '0;
            r_atual      <= '0;
            r_pc_proximo <= PC_W'(PC_RESET);
            r_carrega    <= 1'b0;
            r_troca      <= 1'b0;
            r_ocioso     <= 1'b1;
        end else begin
            r_carrega <= 1'b0;
            r_troca   <= 1'b0;
            if (bus.cria_valido && !w_ativos[bus.cria_id]) begin
                r_pronto[bus.cria_id] <= 1'b1;
                r_pc[bus.cria_id]     <= PC_W'(pc_base(int'(bus.cria_id), PROC_SPAN));
            end
`ifdef ESCALONADOR_IO_BLOQUEIO_EN
            if (bus.io_concluido && r_bloq[bus.io_id]) begin
                r_bloq[bus.io_id]   <= 1'b0;
                r_pronto[bus.io_id] <= 1'b1;
            end
`endif
            case (r_estado)
                OCIOSO: if (|r_pronto) r_estado <= SELECIONA;
                EXECUTA: begin
                    if (bus.step) r_quantum <= r_quantum - 8'd1;
                    if (bus.fim_processo || w_io || w_exp) begin
                        r_motivo <= bus.fim_processo ? MOT_FIM : w_io ? MOT_IO : MOT_QUANTUM;
                        r_estado <= SALVA;
                    end
                end
                SALVA: begin
                    r_pc[r_atual] <= bus.pc_desvio;
                    if (r_motivo != MOT_QUANTUM) begin
                        r_pronto[r_atual] <= 1'b0;
                        r_bloq[r_atual]   <= (r_motivo == MOT_IO);
                    end
                    r_estado <= SELECIONA;
                end
                SELECIONA: begin
                    r_estado <= w_valid ? CARREGA : OCIOSO;
                    r_ocioso <= !w_valid;
                    if (w_valid) begin
                        r_pc_proximo <= r_pc[w_grant];
                        r_carrega    <= 1'b1;
                        r_troca      <= 1'b1;
                        r_quantum    <= 8'(QUANTUM);
                        r_atual      <= w_grant;
                    end
                end
                CARREGA: r_estado <= EXECUTA;
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    assign bus.pc_proximo     = r_pc_proximo;
    assign bus.carrega_pc     = r_carrega;
    assign bus.processo_atual = r_atual;
    assign bus.troca_contexto = r_troca;
    assign bus.ocioso         = r_ocioso;
    assign bus.ativos         = w_ativos;
endmodule

// File: doc/escalonador_processos.md
ESCALONADOR_PROCESSOS -- requirements
Module: escalonador_processos

Interface
REQ-001 SHALL have parameter N_PROC, default 10, number of process slots (2..16).
REQ-002 SHALL have parameter PC_W, default 32, PC width.
REQ-003 SHALL have parameter QUANTUM, default 16, instructions per time slice (1..255).
REQ-004 SHALL have parameter PROC_SPAN, default 300, instruction words per process region; ID_W = clog2(N_PROC).
REQ-005 SHALL have port clock, input, 1, single clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port step, input, 1, one instruction retires this cycle (CPU not halted).
REQ-008 SHALL have port pc_desvio, input, PC_W, datapath's next PC for the current process.
REQ-009 SHALL have port cria_valido, input, 1, activate slot cria_id.
REQ-010 SHALL have port cria_id, input, ID_W, slot to activate.
REQ-011 SHALL have port fim_processo, input, 1, current process terminates.
REQ-012 SHALL have port io_pedido, input, 1, current process issued IN/OUT.
REQ-013 SHALL have port io_concluido, input, 1, pending I/O of blocked slot done (io_id).
REQ-014 SHALL have port io_id, input, ID_W, slot whose I/O completed.
REQ-015 SHALL have port pc_proximo, output, PC_W, PC to load when carrega_pc.
REQ-016 SHALL have port carrega_pc, output, 1, one-cycle PC override strobe.
REQ-017 SHALL have port processo_atual, output, ID_W, running slot.
REQ-018 SHALL have port troca_contexto, output, 1, one-cycle pulse on every dispatch.
REQ-019 SHALL have port ocioso, output, 1, no ready process.
REQ-020 SHALL have port ativos, output, N_PROC, bitmap of slots ready or blocked.

Function
REQ-021 SHALL implement states OCIOSO, EXECUTA, SALVA, SELECIONA, CARREGA.
REQ-022 SHALL, on cria_valido, mark slot ready and set its saved PC to cria_id*PROC_SPAN; activation of an already-active slot is ignored.
REQ-023 SHALL leave OCIOSO for SELECIONA the cycle after any slot becomes ready.
REQ-024 SHALL, in EXECUTA, decrement the quantum counter on each step; counter reaching 0 with step, io_pedido, or fim_processo moves to SALVA next cycle.
REQ-025 SHALL give priority fim_processo > io_pedido > quantum expiry when simultaneous.
REQ-026 SHALL, in SALVA, store pc_desvio into the current slot; fim clears the slot, io_pedido marks it blocked, expiry keeps it ready.
REQ-027 SHALL, in SELECIONA, pick the first ready slot searching round-robin from processo_atual+1 modulo N_PROC (current slot eligible last); none ready -> OCIOSO with ocioso=1.
REQ-028 SHALL, in CARREGA, drive pc_proximo=saved PC, carrega_pc=1, troca_contexto=1 for exactly one cycle, reload quantum to QUANTUM, update processo_atual, enter EXECUTA.
REQ-029 SHALL give dispatch latency of 3 cycles from event to carrega_pc (SALVA, SELECIONA, CARREGA).
REQ-030 SHALL ignore step, io_pedido, fim_processo outside EXECUTA.
REQ-031 SHALL accept cria_valido and io_concluido in any state; io_concluido moves a blocked slot to ready, otherwise ignored; same-cycle set/clear on one slot resolves to the SALVA update.

Reset
REQ-032 SHALL on reset: state OCIOSO, all slots inactive, saved PCs 0, quantum 0, processo_atual 0, pc_proximo 0, carrega_pc 0, troca_contexto 0, ocioso 1, ativos 0.
REQ-033 SHALL abort any in-flight dispatch on reset mid-operation with no strobe emitted.

Configuration
REQ-034 SHALL honour macro ESCALONADOR_IO_BLOQUEIO_EN: defined, io_pedido blocks slot until io_concluido; undefined, io_pedido and io_concluido ignored, I/O never forces a switch.

Structure
REQ-035 SHALL place state enum, default parameter values and PC override constants in package escalonador_pkg.
REQ-036 SHALL implement round-robin search as sub-module seletor_round_robin (request vector, start index -> grant index, valid).

Verification
REQ-037 SHALL cover: reset, cria slot 2 -> after 3 cycles carrega_pc=1, pc_proximo=600, processo_atual=2.
REQ-038 SHALL cover: slots 0,1 active, QUANTUM=4, step held -> switch after 4 steps, slots alternate 0,1,0.
REQ-039 SHALL cover: io_pedido on slot 1 with pc_desvio=645 -> slot 1 skipped; io_concluido id 1 -> next dispatch to slot 1 loads 645.
REQ-040 SHALL cover: fim_processo and io_pedido same cycle on only slot -> slot cleared, ocioso=1, ativos=0.
REQ-041 SHALL cover: reset asserted in SELECIONA -> no carrega_pc, all outputs at reset values.
REQ-042 SHALL cover: macro undefined, io_pedido pulses -> no switch before quantum expiry.
